sc_resultreader: RTL
====================

Name: sc_resultreader

Overview:
- Reader at the far end of the uDATAPATH result interface.
- Samples the 32-bit result bus and the four active-low ALU flags whenever the control state machine strobes a capture.
- Buffers each sample in a small FIFO and hands entries to a downstream consumer (debug logger, display or serializer) over a valid/ready handshake.
- Counts captures lost to a full buffer and keeps sticky flag summaries.

Parameters:
- DATAWIDTH_BUS, 32, width of the datapath result bus.
- FIFO_ADDR_WIDTH, 2, log2 of FIFO depth (default depth 4).
- DATAWIDTH_DROPCOUNT, 8, width of the saturating drop counter.

Ports:
- SC_RESULTREADER_CLOCK_50  in  1  system clock; all logic rising-edge.
- SC_RESULTREADER_RESET_InLow  in  1  synchronous reset, active-low.
- SC_RESULTREADER_data_InBUS  in  DATAWIDTH_BUS  datapath result bus.
- SC_RESULTREADER_overflow_InLow  in  1  overflow flag, 0 = set.
- SC_RESULTREADER_carry_InLow  in  1  carry flag, 0 = set.
- SC_RESULTREADER_negative_InLow  in  1  negative flag, 0 = set.
- SC_RESULTREADER_zero_InLow  in  1  zero flag, 0 = set.
- SC_RESULTREADER_capture_InLow  in  1  capture strobe, 0 = sample this cycle.
- SC_RESULTREADER_ready_In  in  1  consumer accepts head entry when 1.
- SC_RESULTREADER_dropclear_InLow  in  1  0 = clear drop counter and sticky flags.
- SC_RESULTREADER_data_OutBUS  out  DATAWIDTH_BUS  head entry data.
- SC_RESULTREADER_flags_OutBUS  out  4  head entry flags {ovf,carry,neg,zero}, raw active-low.
- SC_RESULTREADER_valid_Out  out  1  head entry valid.
- SC_RESULTREADER_full_Out  out  1  FIFO full.
- SC_RESULTREADER_count_OutBUS  out  FIFO_ADDR_WIDTH+1  occupancy, 0..depth.
- SC_RESULTREADER_dropcount_OutBUS  out  DATAWIDTH_DROPCOUNT  lost captures, saturating.
- SC_RESULTREADER_sticky_OutBUS  out  4  OR of active flags since last clear, active-high.

Behaviour:
- Reset: synchronous, when RESET_InLow = 0 at a clock edge.
  - All outputs 0 after reset: data_OutBUS, flags_OutBUS, valid_Out, full_Out, count_OutBUS, dropcount_OutBUS, sticky_OutBUS.
  - Read and write pointers return to 0.
  - Reset overrides every other input in the same cycle, including mid-burst; all buffered entries are discarded.
- Entry format: {flags[3:0], data[DATAWIDTH_BUS-1:0]}. Flags are stored exactly as received (active-low).
- push = (capture_InLow == 0); pop = valid_Out & ready_In.
- FSM, occupancy-driven, states EMPTY / PARTIAL / FULL:
  - EMPTY: push -> PARTIAL; pop is impossible.
  - PARTIAL: push only -> count+1, go to FULL if count reaches depth; pop only -> count-1, go to EMPTY at 0; push and pop -> count unchanged, state unchanged.
  - FULL: pop only -> PARTIAL; push and pop -> accepted, stays FULL; push only -> dropped, stays FULL.
- Latency: a sample pushed into EMPTY appears on data_OutBUS/flags_OutBUS with valid_Out = 1 on the next cycle. Head is first-word-fall-through.
- When valid_Out = 0, data_OutBUS and flags_OutBUS hold their last values (0 after reset).
- Head entry, valid_Out and data remain stable while valid_Out = 1 and ready_In = 0.
- Pointers wrap modulo depth. Count distinguishes full from empty via the extra bit.
- full_Out = 1 exactly when count == depth.
- dropcount: +1 per dropped push (push only while FULL).
  - Saturates at 2^DATAWIDTH_DROPCOUNT - 1.
  - dropclear_InLow = 0 forces it to 0 next cycle; clear wins over a simultaneous drop.
- sticky: sticky[i] |= ~flag_i on each accepted push only (dropped pushes do not update it). dropclear_InLow = 0 clears it and wins over an update.
- Single-cycle strobe: every cycle with capture_InLow = 0 is a separate sample; back-to-back strobes push on consecutive cycles.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0; valid_Out = 0, count = 0.
- Capture 0x0000000F with zero_InLow = 1 and other flags = 1, ready_In = 0 -> next cycle valid_Out = 1, data = 0x0000000F, flags = 4'b1111, count = 1.
- Capture 6 back-to-back values 1..6 with ready_In = 0 -> full_Out = 1 after the 4th, count = 4, dropcount = 2. Then ready_In = 1 -> reads 1, 2, 3, 4 in order, then valid_Out = 0.
- FULL with capture and ready_In = 1 in the same cycle -> count stays 4, dropcount unchanged, new value read last.
- Capture with carry_InLow = 0 and negative_InLow = 0 -> sticky = 4'b0110. Then dropclear_InLow = 0 -> sticky = 0 and dropcount = 0.
- Fill 3 entries, assert RESET_InLow = 0 for 1 cycle while capture is also asserted -> count = 0, valid_Out = 0, no entry retained.
- Drive 300 drops with DATAWIDTH_DROPCOUNT = 8 -> dropcount saturates at 255.

Source files
------------

// File: rtl/sc_resultreader.sv
// Result-bus reader: captures {flags, data} on a strobe into a small FWFT FIFO,
// serves the head over valid/ready, and tracks dropped captures and sticky flags.
module sc_resultreader #(
  parameter int DATAWIDTH_BUS       = 32,
  parameter int FIFO_ADDR_WIDTH     = 2,
  parameter int DATAWIDTH_DROPCOUNT = 8
) (
  input  logic                           SC_RESULTREADER_CLOCK_50,
  input  logic                           SC_RESULTREADER_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]       SC_RESULTREADER_data_InBUS,
  input  logic                           SC_RESULTREADER_overflow_InLow,
  input  logic                           SC_RESULTREADER_carry_InLow,
  input  logic                           SC_RESULTREADER_negative_InLow,
  input  logic                           SC_RESULTREADER_zero_InLow,
  input  logic                           SC_RESULTREADER_capture_InLow,
  input  logic                           SC_RESULTREADER_ready_In,
  input  logic                           SC_RESULTREADER_dropclear_InLow,
  output logic [DATAWIDTH_BUS-1:0]       SC_RESULTREADER_data_OutBUS,
  output logic [3:0]                     SC_RESULTREADER_flags_OutBUS,
  output logic                           SC_RESULTREADER_valid_Out,
  output logic                           SC_RESULTREADER_full_Out,
  output logic [FIFO_ADDR_WIDTH:0]       SC_RESULTREADER_count_OutBUS,
  output logic [DATAWIDTH_DROPCOUNT-1:0] SC_RESULTREADER_dropcount_OutBUS,
  output logic [3:0]                     SC_RESULTREADER_sticky_OutBUS
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DC    = DATAWIDTH_DROPCOUNT;
  localparam int EW    = DATAWIDTH_BUS + 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic          clk;
  logic          rst_n;
  logic [EW-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, count_after_pop;
  logic [EW-1:0] head_q, head_d;
  logic [DC-1:0] drop_q, drop_d;
  logic [3:0]    sticky_q, sticky_d;

  logic [3:0]    push_flags;
  logic [EW-1:0] push_entry;
  logic          push, pop, drop, accept, clear;

  assign clk        = SC_RESULTREADER_CLOCK_50;
  assign rst_n      = SC_RESULTREADER_RESET_InLow;
  assign push_flags = {SC_RESULTREADER_overflow_InLow, SC_RESULTREADER_carry_InLow,
                       SC_RESULTREADER_negative_InLow, SC_RESULTREADER_zero_InLow};
  assign push_entry = {push_flags, SC_RESULTREADER_data_InBUS};

  assign push   = ~SC_RESULTREADER_capture_InLow;
  assign pop    = (state_q != ST_EMPTY) & SC_RESULTREADER_ready_In;
  assign drop   = push & (state_q == ST_FULL) & ~pop;
  assign accept = push & ~drop;
  assign clear  = ~SC_RESULTREADER_dropclear_InLow;

  always_comb begin
    rd_ptr_d        = rd_ptr_q + AW'(pop);
    wr_ptr_d        = wr_ptr_q + AW'(accept);
    count_after_pop = count_q - (AW+1)'(pop);
    count_d         = count_after_pop + (AW+1)'(accept);

    // Head register is refilled from the next read slot, or straight from the
    // input when the buffer would otherwise run dry; it holds when empty.
    head_d = head_q;
    if (count_d != '0) begin
      if (count_after_pop == '0) begin
        head_d = push_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == DEPTH_CNT) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end

    drop_d = drop_q;
    if (clear) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DC'(1);
    end

    sticky_d = sticky_q;
    if (clear) begin
      sticky_d = '0;
    end else if (accept) begin
      sticky_d = sticky_q | ~push_flags;
    end
  end

  // Storage carries no reset: stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
      sticky_q <= sticky_d;
    end
  end

  assign SC_RESULTREADER_data_OutBUS      = head_q[DATAWIDTH_BUS-1:0];
  assign SC_RESULTREADER_flags_OutBUS     = head_q[EW-1:DATAWIDTH_BUS];
  assign SC_RESULTREADER_valid_Out        = (state_q != ST_EMPTY);
  assign SC_RESULTREADER_full_Out         = (state_q == ST_FULL);
  assign SC_RESULTREADER_count_OutBUS     = count_q;
  assign SC_RESULTREADER_dropcount_OutBUS = drop_q;
  assign SC_RESULTREADER_sticky_OutBUS    = sticky_q;

endmodule
